and_reduce_collector: RTL and testbench

- Upstream feeder for the 4-lane bitwise AND stage.
- Accepts a valid/ready stream of WIDTH-bit words and collects up to BEATS consecutive words into lane registers.
- Produces the lane-wise AND of the group, plus its beat count, on a registered valid/ready output.
- Groups can be closed early with in_last; unused lanes act as the AND identity (all-ones).

---
 rtl/and_reduce_collector_pkg.sv | 18 +
 rtl/and_reduce_collector_and_lanes.sv | 14 +
 rtl/and_reduce_collector.sv | 80 ++++++++
 tb/tb_and_reduce_collector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/and_reduce_collector_pkg.sv
// Shared types and constants for the AND-reduce collector: FSM states,
// the AND identity used to seed the accumulator, and the counter-width helper.
package and_reduce_collector_pkg;

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   localparam int DEF_WIDTH = 2;
   localparam int DEF_BEATS = 4;
   localparam int MAX_WIDTH = 64;

   // All-ones identity for AND; sliced down to the lane width by users.
   localparam logic [MAX_WIDTH-1:0] LANE_ONES = '1;

   function automatic int cw_of(input int beats);
      return $clog2(beats + 1);
   endfunction

endpackage

// File: rtl/and_reduce_collector_and_lanes.sv
// Combinational two-operand lane-wise AND used for the accumulator update.
module and_lanes #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign y[i] = a[i] & b[i];
   end

endmodule

// File: rtl/and_reduce_collector.sv
// Collects up to BEATS words from a valid/ready stream and emits their
// lane-wise AND plus the beat count on a registered valid/ready output.
module and_reduce_collector
   import and_reduce_collector_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int BEATS = DEF_BEATS,
   localparam int CW    = cw_of(BEATS)
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [WIDTH-1:0] ACC_ONES = LANE_ONES[WIDTH-1:0];

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_and;
   logic [CW-1:0]    cnt;
   logic             accept, close;

   and_lanes #(.WIDTH(WIDTH)) u_and_lanes (
      .a (acc),
      .b (in_data),
      .y (acc_and)
   );

   assign accept = in_valid && in_ready;
   // In HOLD acc/cnt are already reset, so the same close rule starts a fresh group.
   assign close  = in_last || (cnt == CW'(BEATS - 1));

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) state <= FILL;
      else              state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         FILL: if (accept && close) state_n = HOLD;
         HOLD: if (out_ready)       state_n = (accept && close) ? HOLD : FILL;
         default:                   state_n = FILL;
      endcase
   end

   always_comb begin
      in_ready = (state == FILL) || out_ready;
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         acc       <= ACC_ONES;
         cnt       <= '0;
         out_data  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_n == HOLD);
         if (accept) begin
            if (close) begin
               out_data  <= acc_and;
               out_count <= cnt + 1'b1;
               acc       <= ACC_ONES;
               cnt       <= '0;
            end else begin
               acc <= acc_and;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_and_reduce_collector.sv
// Scoreboard bench for and_reduce_collector: directed groups push expected
// results; a monitor pops and compares on every output handshake.
module tb_and_reduce_collector;

   localparam int WIDTH = 2;
   localparam int CW    = 3;

   logic             CLK = 1'b0;
   logic             ASYNCRESETN = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_count;
   logic             out_valid;
   logic             out_ready = 1'b1;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic [CW-1:0]    c;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   and_reduce_collector #(.WIDTH(WIDTH), .BEATS(4)) dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_count   (out_count),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] d, input logic [CW-1:0] c);
      exp_t e;
      e.d = d;
      e.c = c;
      q.push_back(e);
   endtask

   // Present one word and hold it until accepted; returns stall cycles.
   task automatic beat(input logic [WIDTH-1:0] d, input logic l, output int waits);
      logic rdy;
      logic done;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      waits    = 0;
      done     = 1'b0;
      while (!done) begin
         @(negedge CLK);
         rdy = in_ready;
         @(posedge CLK);
         #1;
         if (rdy) done = 1'b1;
         else begin
            waits++;
            if (waits > 50) begin
               checks++;
               errors++;
               $display("FAIL beat_timeout: in_ready stuck at 0 for word %0h", d);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   always @(negedge CLK) begin
      if (ASYNCRESETN && out_valid && out_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: data %0h count %0d with empty scoreboard", out_data, out_count);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (out_data !== e.d || out_count !== e.c) begin
               errors++;
               $display("FAIL result: got data %0h count %0d expected data %0h count %0d at %0t",
                        out_data, out_count, e.d, e.c, $time);
            end
         end
      end
   end

   initial begin
      int w;
      logic [WIDTH-1:0] b2b [4];
      b2b[0] = 2'b11; b2b[1] = 2'b10; b2b[2] = 2'b01; b2b[3] = 2'b00;

      // Reset state while held in reset
      @(posedge CLK); #3;
      chk("rst_out_valid", 8'(out_valid), 8'h0);
      chk("rst_out_data",  8'(out_data),  8'h0);
      chk("rst_out_count", 8'(out_count), 8'h0);
      @(posedge CLK); #1;
      ASYNCRESETN = 1'b1;
      #1;
      chk("rst_in_ready", 8'(in_ready), 8'h1);
      @(posedge CLK); #1;

      // Full group, no in_last
      push(2'b10, 3'd4);
      beat(2'b11, 1'b0, w);
      beat(2'b11, 1'b0, w);
      beat(2'b10, 1'b0, w);
      beat(2'b11, 1'b0, w);
      idle();
      chk("full_valid_hi", 8'(out_valid), 8'h1);
      @(posedge CLK); #1;
      chk("full_valid_lo", 8'(out_valid), 8'h0);

      // Early close, then a 3-beat group
      push(2'b01, 3'd2);
      beat(2'b11, 1'b0, w);
      beat(2'b01, 1'b1, w);
      push(2'b10, 3'd3);
      beat(2'b10, 1'b0, w);
      beat(2'b11, 1'b0, w);
      beat(2'b11, 1'b1, w);
      idle();
      @(posedge CLK); #1;

      // Backpressure
      out_ready = 1'b0;
      push(2'b01, 3'd4);
      for (int i = 0; i < 4; i++) beat(2'b01, 1'b0, w);
      idle();
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         chk("bp_in_ready",  8'(in_ready),  8'h0);
         chk("bp_out_valid", 8'(out_valid), 8'h1);
         chk("bp_out_data",  8'(out_data),  8'h1);
         chk("bp_out_count", 8'(out_count), 8'h4);
      end
      out_ready = 1'b1;
      beat(2'b00, 1'b0, w);
      chk("bp_same_cycle_accept", 8'(w), 8'h0);
      idle();
      chk("bp_valid_drop", 8'(out_valid), 8'h0);
      push(2'b00, 3'd4);
      for (int i = 0; i < 3; i++) beat(2'b11, 1'b0, w);
      idle();
      @(posedge CLK); #1;

      // Back-to-back single-beat groups
      for (int i = 0; i < 4; i++) push(b2b[i], 3'd1);
      for (int i = 0; i < 4; i++) begin
         beat(b2b[i], 1'b1, w);
         chk("b2b_no_stall",  8'(w),         8'h0);
         chk("b2b_out_valid", 8'(out_valid), 8'h1);
         chk("b2b_in_ready",  8'(in_ready),  8'h1);
      end
      idle();
      @(posedge CLK); #1;
      chk("b2b_valid_lo", 8'(out_valid), 8'h0);

      // Asynchronous reset clears a held result immediately
      out_ready = 1'b0;
      beat(2'b11, 1'b1, w);
      idle();
      @(posedge CLK); #3;
      ASYNCRESETN = 1'b0;
      #1;
      chk("async_out_valid", 8'(out_valid), 8'h0);
      chk("async_out_data",  8'(out_data),  8'h0);
      chk("async_out_count", 8'(out_count), 8'h0);
      @(posedge CLK); #1;
      ASYNCRESETN = 1'b1;
      out_ready = 1'b1;
      @(posedge CLK); #1;

      // Reset mid-group discards partial accumulation
      beat(2'b00, 1'b0, w);
      beat(2'b00, 1'b0, w);
      idle();
      #3 ASYNCRESETN = 1'b0;
      #2 ASYNCRESETN = 1'b1;
      @(posedge CLK); #1;
      push(2'b01, 3'd4);
      for (int i = 0; i < 4; i++) beat(2'b01, 1'b0, w);
      idle();

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
      #1;
      chk("scoreboard_drained", 8'(q.size()), 8'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
